// File: rtl/activation_pair_fetcher_pkg.sv
// Shared definitions for the activation-stack read/write sequencers.
// The state encoding is common to the forward-side writer and the backward fetcher.
package activation_pair_fetcher_pkg;

    localparam int DEFAULT_NEURON_NUM       = 6;
    localparam int DEFAULT_ACTIVATION_WIDTH = 8;
    localparam int DEFAULT_STACK_ADDR_WIDTH = 10;
    localparam int STACK_WIDTH              = DEFAULT_NEURON_NUM * DEFAULT_ACTIVATION_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/activation_pair_fetcher_pair_capture_reg.sv
// Two-slot capture register: the lower and higher stack words arrive on independent
// handshakes in any order; both_full also counts words being taken this cycle.
module pair_capture_reg
    import activation_pair_fetcher_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             arm,
    input  logic [WIDTH-1:0] lower_data,
    input  logic             lower_valid,
    output logic             lower_ready,
    input  logic [WIDTH-1:0] higher_data,
    input  logic             higher_valid,
    output logic             higher_ready,
    output logic [WIDTH-1:0] lower_word,
    output logic [WIDTH-1:0] higher_word,
    output logic             both_full
);

    logic             got_lo;
    logic             got_hi;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             lo_take;
    logic             hi_take;

    assign lower_ready  = arm && !got_lo;
    assign higher_ready = arm && !got_hi;
    assign lo_take      = lower_valid && lower_ready;
    assign hi_take      = higher_valid && higher_ready;

    // Bypass lets the owner load its output registers in the capture cycle itself.
    assign lower_word  = lo_take ? lower_data : lo_q;
    assign higher_word = hi_take ? higher_data : hi_q;
    assign both_full   = (got_lo || lo_take) && (got_hi || hi_take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got_lo <= 1'b0;
            got_hi <= 1'b0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else if (clear) begin
            got_lo <= 1'b0;
            got_hi <= 1'b0;
        end else begin
            if (lo_take) begin
                got_lo <= 1'b1;
                lo_q   <= lower_data;
            end
            if (hi_take) begin
                got_hi <= 1'b1;
                hi_q   <= higher_data;
            end
        end
    end

endmodule

// File: rtl/activation_pair_fetcher.sv
// Backward-pass sequencer: reads activation pairs (a[k], a[k+1]) from the stack for
// k = L-1 down to 0, one outstanding read at a time, and emits one packet per pair.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | ready for a start request; L==0 just pulses done
//  REQ     | stack_addr = cur presented until the stack accepts it
//  WAIT    | collecting lower/higher words for cur
//  OUT     | packet for cur held until the datapath accepts it
module activation_pair_fetcher
    import activation_pair_fetcher_pkg::*;
#(
    parameter int NEURON_NUM       = DEFAULT_NEURON_NUM,
    parameter int ACTIVATION_WIDTH = DEFAULT_ACTIVATION_WIDTH,
    parameter int STACK_ADDR_WIDTH = DEFAULT_STACK_ADDR_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [STACK_ADDR_WIDTH-1:0]            start_layers,
    input  logic                                   start_valid,
    output logic                                   start_ready,
    output logic [STACK_ADDR_WIDTH-1:0]            stack_addr,
    output logic                                   stack_addr_valid,
    input  logic                                   stack_addr_ready,
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0] stack_lower,
    input  logic                                   stack_lower_valid,
    output logic                                   stack_lower_ready,
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0] stack_higher,
    input  logic                                   stack_higher_valid,
    output logic                                   stack_higher_ready,
    output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0] out_lower,
    output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0] out_higher,
    output logic [STACK_ADDR_WIDTH-1:0]            out_layer,
    output logic                                   out_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   done
);

    localparam int SW = NEURON_NUM * ACTIVATION_WIDTH;

    seq_state_t                  state;
    logic [STACK_ADDR_WIDTH-1:0] cur;
    logic                        addr_xfer;
    logic                        cap_clear;
    logic                        cap_arm;
    logic                        cap_both;
    logic [SW-1:0]               cap_lower;
    logic [SW-1:0]               cap_higher;

    assign start_ready = (state == ST_IDLE);
    assign stack_addr  = cur;
    assign addr_xfer   = stack_addr_valid && stack_addr_ready;
    assign cap_clear   = (state == ST_REQ) && addr_xfer;
    assign cap_arm     = (state == ST_WAIT);

    pair_capture_reg #(
        .WIDTH (SW)
    ) u_capture (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (cap_clear),
        .arm          (cap_arm),
        .lower_data   (stack_lower),
        .lower_valid  (stack_lower_valid),
        .lower_ready  (stack_lower_ready),
        .higher_data  (stack_higher),
        .higher_valid (stack_higher_valid),
        .higher_ready (stack_higher_ready),
        .lower_word   (cap_lower),
        .higher_word  (cap_higher),
        .both_full    (cap_both)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cur              <= '0;
            stack_addr_valid <= 1'b0;
            out_lower        <= '0;
            out_higher       <= '0;
            out_layer        <= '0;
            out_last         <= 1'b0;
            out_valid        <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        if (start_layers == '0) begin
                            done <= 1'b1;
                        end else begin
                            cur              <= start_layers - 1'b1;
                            stack_addr_valid <= 1'b1;
                            state            <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (addr_xfer) begin
                        stack_addr_valid <= 1'b0;
                        state            <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cap_both) begin
                        out_lower  <= cap_lower;
                        out_higher <= cap_higher;
                        out_layer  <= cur;
                        out_last   <= (cur == '0);
                        out_valid  <= 1'b1;
                        state      <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cur == '0) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            cur              <= cur - 1'b1;
                            stack_addr_valid <= 1'b1;
                            state            <= ST_REQ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_pair_fetcher.sv
// Directed bench for activation_pair_fetcher: behavioural stack responder plus a
// scoreboard of expected addresses and packets checked at each handshake.
module tb_activation_pair_fetcher;

    localparam int SW  = 48;
    localparam int SAW = 10;

    typedef struct packed {
        logic [SAW-1:0] layer;
        logic [SW-1:0]  lo;
        logic [SW-1:0]  hi;
        logic           last;
    } pkt_t;

    logic           clk;
    logic           rst_n;
    logic [SAW-1:0] start_layers;
    logic           start_valid;
    logic           start_ready;
    logic [SAW-1:0] stack_addr;
    logic           stack_addr_valid;
    logic           stack_addr_ready;
    logic [SW-1:0]  stack_lower;
    logic           stack_lower_valid;
    logic           stack_lower_ready;
    logic [SW-1:0]  stack_higher;
    logic           stack_higher_valid;
    logic           stack_higher_ready;
    logic [SW-1:0]  out_lower;
    logic [SW-1:0]  out_higher;
    logic [SAW-1:0] out_layer;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;
    logic           done;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   addr_cycles = 0;
    int   lo_delay = 0;
    int   hi_delay = 0;
    pkt_t exp_q[$];
    int   addr_q[$];

    activation_pair_fetcher dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_layers       (start_layers),
        .start_valid        (start_valid),
        .start_ready        (start_ready),
        .stack_addr         (stack_addr),
        .stack_addr_valid   (stack_addr_valid),
        .stack_addr_ready   (stack_addr_ready),
        .stack_lower        (stack_lower),
        .stack_lower_valid  (stack_lower_valid),
        .stack_lower_ready  (stack_lower_ready),
        .stack_higher       (stack_higher),
        .stack_higher_valid (stack_higher_valid),
        .stack_higher_ready (stack_higher_ready),
        .out_lower          (out_lower),
        .out_higher         (out_higher),
        .out_layer          (out_layer),
        .out_last           (out_last),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .done               (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] row(input int i);
        logic [7:0] b;
        b = 8'(i * 17);
        return {6{b}};
    endfunction

    // Row r holds byte r*0x11 in every lane; a[k] = row(k), a[k+1] = row(k+1).
    task automatic expect_run(input int layers);
        pkt_t p;
        for (int k = layers - 1; k >= 0; k--) begin
            p.layer = SAW'(k);
            p.lo    = row(k);
            p.hi    = row(k + 1);
            p.last  = (k == 0);
            exp_q.push_back(p);
            addr_q.push_back(k);
        end
    endtask

    // Stack responder: handshakes are predicted at the negedge, inputs change 1ns after posedge.
    initial begin
        int  a;
        int  clo;
        int  chi;
        bit  plo;
        bit  phi;
        bit  fa;
        bit  fl;
        bit  fh;
        stack_addr_ready   = 1'b1;
        stack_lower        = '0;
        stack_higher       = '0;
        stack_lower_valid  = 1'b0;
        stack_higher_valid = 1'b0;
        plo = 0; phi = 0; clo = 0; chi = 0; a = 0;
        forever begin
            @(negedge clk);
            fa = stack_addr_valid && stack_addr_ready;
            fl = stack_lower_valid && stack_lower_ready;
            fh = stack_higher_valid && stack_higher_ready;
            if (fa) a = int'(stack_addr);
            @(posedge clk);
            #1;
            if (!rst_n) begin
                plo = 0;
                phi = 0;
                stack_lower_valid  = 1'b0;
                stack_higher_valid = 1'b0;
            end else begin
                if (fl) stack_lower_valid = 1'b0;
                if (fh) stack_higher_valid = 1'b0;
                if (fa) begin
                    plo = 1; phi = 1; clo = lo_delay; chi = hi_delay;
                end
                if (plo) begin
                    if (clo == 0) begin
                        stack_lower       = row(a);
                        stack_lower_valid = 1'b1;
                        plo = 0;
                    end else clo--;
                end
                if (phi) begin
                    if (chi == 0) begin
                        stack_higher       = row(a + 1);
                        stack_higher_valid = 1'b1;
                        phi = 0;
                    end else chi--;
                end
            end
        end
    end

    // Scoreboard side: compare every address and packet transfer against the queues.
    initial begin
        pkt_t p;
        int   ea;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) done_cnt++;
                if (stack_addr_valid) addr_cycles++;
                if (stack_addr_valid && stack_addr_ready) begin
                    if (addr_q.size() == 0) chk("addr_unexpected", 64'(stack_addr), 64'hFFFF);
                    else begin
                        ea = addr_q.pop_front();
                        chk("stack_addr", 64'(stack_addr), 64'(ea));
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("pkt_unexpected", 64'(out_layer), 64'hFFFF);
                    else begin
                        p = exp_q.pop_front();
                        chk("out_layer", 64'(out_layer), 64'(p.layer));
                        chk("out_lower", 64'(out_lower), 64'(p.lo));
                        chk("out_higher", 64'(out_higher), 64'(p.hi));
                        chk("out_last", 64'(out_last), 64'(p.last));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int layers);
        bit got;
        got = 0;
        expect_run(layers);
        start_layers = SAW'(layers);
        start_valid  = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (start_ready) got = 1;
            step();
        end
        start_valid = 1'b0;
        chk("start_accepted", 64'(got), 64'd1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 500 && done_cnt < target; i++) @(negedge clk);
        step();
        step();
        chk("done_count", 64'(done_cnt), 64'(target));
    endtask

    initial begin
        int   base;
        int   acyc;
        bit   seen;
        bit   stable;
        bit   noaddr;
        logic [SW-1:0]  s_lo;
        logic [SW-1:0]  s_hi;
        logic [SAW-1:0] s_layer;

        rst_n        = 1'b0;
        start_valid  = 1'b0;
        start_layers = '0;
        out_ready    = 1'b1;
        #2;
        chk("reset_outputs",
            64'({start_ready, stack_addr_valid, stack_lower_ready, stack_higher_ready, out_valid, done}),
            64'b100000);
        chk("reset_data", 64'({out_lower, out_layer} | 58'(stack_addr)), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 1: three layers, free-flowing.
        base = done_cnt;
        do_start(3);
        wait_done(base + 1);

        // 2: zero layers -> done next cycle, no reads.
        base = done_cnt;
        acyc = addr_cycles;
        do_start(0);
        @(negedge clk);
        chk("empty_done_next", 64'(done), 64'd1);
        step();
        @(negedge clk);
        chk("empty_done_single", 64'(done), 64'd0);
        step();
        chk("empty_done_count", 64'(done_cnt), 64'(base + 1));
        chk("empty_no_addr", 64'(addr_cycles), 64'(acyc));

        // 3: higher word three cycles ahead of lower.
        lo_delay = 3;
        hi_delay = 0;
        base = done_cnt;
        do_start(1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (stack_higher_valid && stack_higher_ready) seen = 1;
        end
        chk("hi_first_seen", 64'(seen), 64'd1);
        @(negedge clk);
        chk("hi_first_ready",
            64'({stack_higher_ready, stack_lower_ready, stack_lower_valid, out_valid}), 64'b0100);
        step();
        wait_done(base + 1);
        lo_delay = 0;

        // 4: back-pressure on k=1.
        base = done_cnt;
        do_start(3);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid && out_layer == SAW'(2)) seen = 1;
        end
        step();
        out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("bp_valid_seen", 64'(seen), 64'd1);
        s_lo = out_lower;
        s_hi = out_higher;
        s_layer = out_layer;
        chk("bp_layer", 64'(s_layer), 64'd1);
        stable = 1;
        noaddr = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || out_lower !== s_lo || out_higher !== s_hi || out_layer !== s_layer)
                stable = 0;
            if (stack_addr_valid) noaddr = 0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        chk("bp_no_addr", 64'(noaddr), 64'd1);
        step();
        out_ready = 1'b1;
        wait_done(base + 1);

        // 5: start pulses mid-run are ignored.
        base = done_cnt;
        do_start(3);
        for (int i = 0; i < 3; i++) begin
            start_layers = SAW'(7);
            start_valid  = 1'b1;
            @(negedge clk);
            chk("busy_start_ready", 64'(start_ready), 64'd0);
            step();
        end
        start_valid = 1'b0;
        wait_done(base + 1);
        chk("busy_queue_empty", 64'(exp_q.size()), 64'd0);

        // 6: reset in WAIT of k=4, then restart with L=2.
        lo_delay = 2;
        hi_delay = 2;
        do_start(6);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (stack_lower_ready && stack_addr == SAW'(4)) seen = 1;
        end
        chk("rst_wait_k4_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs",
            64'({start_ready, stack_addr_valid, stack_lower_ready, stack_higher_ready, out_valid, done}),
            64'b100000);
        chk("rst_data", 64'({out_lower, out_layer}), 64'd0);
        exp_q.delete();
        addr_q.delete();
        base = done_cnt;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_no_done", 64'(done_cnt), 64'(base));
        lo_delay = 0;
        hi_delay = 0;
        do_start(2);
        wait_done(base + 1);

        chk("final_pkt_queue", 64'(exp_q.size()), 64'd0);
        chk("final_addr_queue", 64'(addr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
